// File: rtl/tick_pwm.sv
// Tick-driven PWM generator: counts divider strobes over a shadowed period and
// drives a registered PWM level and a period-boundary pulse. Optional input
// synchronizers on period/duty are enabled by defining TICK_PWM_SYNC_EN.
module tick_pwm #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             pwm_o,
  output logic             period_end_o
);

  logic [WIDTH-1:0] period_src;
  logic [WIDTH-1:0] duty_src;

`ifdef TICK_PWM_SYNC_EN
  // Switch inputs are asynchronous to sys_clk; two flops settle metastability.
  logic [WIDTH-1:0] period_meta, period_sync;
  logic [WIDTH-1:0] duty_meta, duty_sync;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      period_meta <= '0;
      period_sync <= '0;
      duty_meta   <= '0;
      duty_sync   <= '0;
    end else begin
      period_meta <= period_i;
      period_sync <= period_meta;
      duty_meta   <= duty_i;
      duty_sync   <= duty_meta;
    end
  end

  assign period_src = period_sync;
  assign duty_src   = duty_sync;
`else
  assign period_src = period_i;
  assign duty_src   = duty_i;
`endif

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] per_sh;
  logic [WIDTH-1:0] duty_sh;

  // NOTE: non-blocking assignments let pwm_o compare the pre-edge cnt and
  // duty_sh even though both are updated in the same block.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt          <= '0;
      per_sh       <= '0;
      duty_sh      <= '0;
      pwm_o        <= 1'b0;
      period_end_o <= 1'b0;
    end else if (!en_i) begin
      cnt          <= '0;
      per_sh       <= period_src;
      duty_sh      <= duty_src;
      pwm_o        <= 1'b0;
      period_end_o <= 1'b0;
    end else begin
      pwm_o        <= (cnt < duty_sh);
      period_end_o <= 1'b0;
      if (tick_i) begin
        if (cnt == per_sh) begin
          cnt          <= '0;
          per_sh       <= period_src;
          duty_sh      <= duty_src;
          period_end_o <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
